// File: rtl/icb_dma_master.sv
// ICB block-copy initiator: reads up to FIFO_DEPTH words into a staging buffer, then writes them out.
// Runs one outstanding transaction at a time and repeats chunk by chunk until len words are moved or an error response arrives.
//
// state    | meaning
// ---------+-------------------------------------------------------
// S_IDLE   | waiting for start; command/response handshakes idle
// S_RD_CMD | read command to source pointer on the bus
// S_RD_RSP | waiting for read data, stored at rd_idx
// S_WR_CMD | write command of buffer[wr_idx] to destination pointer
// S_WR_RSP | waiting for write acknowledge
// S_FIN    | one-cycle done pulse, then back to S_IDLE
module icb_dma_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             icb_cmd_valid,
    input  logic             icb_cmd_ready,
    output logic             icb_cmd_read,
    output logic [31:0]      icb_cmd_addr,
    output logic [31:0]      icb_cmd_wdata,
    output logic [3:0]       icb_cmd_wmask,
    input  logic             icb_rsp_valid,
    output logic             icb_rsp_ready,
    input  logic [31:0]      icb_rsp_rdata,
    input  logic             icb_rsp_err
);

    localparam int IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_CMD,
        S_RD_RSP,
        S_WR_CMD,
        S_WR_RSP,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] rem_dec;
    logic [CNT_W-1:0] chunk_q, chunk_d;
    // Down-counter of words left in the current read or write phase of a chunk.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             err_q, err_d;
    logic             fifo_we;
    logic [31:0]      fifo_q [FIFO_DEPTH];

    logic cmd_hs;
    logic rsp_hs;

    function automatic logic [CNT_W-1:0] chunk_of(input logic [LEN_W-1:0] words);
        if (words > LEN_W'(FIFO_DEPTH)) begin
            return CNT_W'(FIFO_DEPTH);
        end
        return words[CNT_W-1:0];
    endfunction

    assign cmd_hs  = icb_cmd_valid & icb_cmd_ready;
    assign rsp_hs  = icb_rsp_valid & icb_rsp_ready;
    assign rem_dec = rem_q - 1'b1;

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        rem_d    = rem_q;
        chunk_d  = chunk_q;
        cnt_d    = cnt_q;
        rd_idx_d = rd_idx_q;
        wr_idx_d = wr_idx_q;
        err_d    = err_q;
        fifo_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d    = src_addr;
                    dst_d    = dst_addr;
                    rem_d    = len;
                    err_d    = 1'b0;
                    chunk_d  = chunk_of(len);
                    cnt_d    = chunk_of(len);
                    rd_idx_d = '0;
                    state_d  = (len == '0) ? S_FIN : S_RD_CMD;
                end
            end
            S_RD_CMD: begin
                if (cmd_hs) begin
                    state_d = S_RD_RSP;
                end
            end
            S_RD_RSP: begin
                if (rsp_hs) begin
                    if (icb_rsp_err) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        fifo_we  = 1'b1;
                        src_d    = src_q + 32'd4;
                        rd_idx_d = rd_idx_q + 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            cnt_d    = chunk_q;
                            wr_idx_d = '0;
                            state_d  = S_WR_CMD;
                        end else begin
                            cnt_d   = cnt_q - 1'b1;
                            state_d = S_RD_CMD;
                        end
                    end
                end
            end
            S_WR_CMD: begin
                if (cmd_hs) begin
                    state_d = S_WR_RSP;
                end
            end
            S_WR_RSP: begin
                if (rsp_hs) begin
                    if (icb_rsp_err) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        dst_d    = dst_q + 32'd4;
                        rem_d    = rem_dec;
                        wr_idx_d = wr_idx_q + 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            if (rem_q == LEN_W'(1)) begin
                                state_d = S_FIN;
                            end else begin
                                chunk_d  = chunk_of(rem_dec);
                                cnt_d    = chunk_of(rem_dec);
                                rd_idx_d = '0;
                                state_d  = S_RD_CMD;
                            end
                        end else begin
                            cnt_d   = cnt_q - 1'b1;
                            state_d = S_WR_CMD;
                        end
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            chunk_q  <= '0;
            cnt_q    <= '0;
            rd_idx_q <= '0;
            wr_idx_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            rem_q    <= rem_d;
            chunk_q  <= chunk_d;
            cnt_q    <= cnt_d;
            rd_idx_q <= rd_idx_d;
            wr_idx_q <= wr_idx_d;
            err_q    <= err_d;
        end
    end

    // Staging buffer carries no reset; it is always filled before it is read.
    always_ff @(posedge clk) begin
        if (fifo_we) begin
            fifo_q[rd_idx_q] <= icb_rsp_rdata;
        end
    end

    // Every output decodes registered state only, so command fields hold steady through stalls.
    assign icb_cmd_valid = (state_q == S_RD_CMD) || (state_q == S_WR_CMD);
    assign icb_cmd_read  = (state_q == S_RD_CMD);
    assign icb_cmd_addr  = (state_q == S_RD_CMD) ? src_q :
                           (state_q == S_WR_CMD) ? dst_q : 32'h0;
    assign icb_cmd_wdata = (state_q == S_WR_CMD) ? fifo_q[wr_idx_q] : 32'h0;
    assign icb_cmd_wmask = (state_q == S_WR_CMD) ? 4'hF : 4'h0;
    assign icb_rsp_ready = (state_q == S_RD_RSP) || (state_q == S_WR_RSP);
    assign busy          = icb_cmd_valid | icb_rsp_ready;
    assign done          = (state_q == S_FIN);
    assign err           = err_q;

    a_cmd_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (icb_cmd_valid && !icb_cmd_ready) |=>
            (icb_cmd_valid && $stable(icb_cmd_addr) && $stable(icb_cmd_wdata) && $stable(icb_cmd_read)));

endmodule

// File: tb/tb_icb_dma_master.sv
// Bench for icb_dma_master: table of transfers against a memory-backed ICB slave with random stalls.
// The expected bus command list and destination contents come from a chunk-level model of the copy.
`timescale 1ns/1ps
module tb_icb_dma_master;

    localparam int DEPTH = 4;
    localparam int LW    = 13;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   src_addr = '0;
    logic [31:0]   dst_addr = '0;
    logic [LW-1:0] len = '0;
    logic          busy, done, err;
    logic          icb_cmd_valid, icb_cmd_read;
    logic          icb_cmd_ready = 1'b0;
    logic [31:0]   icb_cmd_addr, icb_cmd_wdata;
    logic [3:0]    icb_cmd_wmask;
    logic          icb_rsp_valid = 1'b0;
    logic          icb_rsp_ready;
    logic [31:0]   icb_rsp_rdata = '0;
    logic          icb_rsp_err = 1'b0;

    icb_dma_master #(.FIFO_DEPTH(DEPTH), .LEN_W(LW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .len           (len),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } cmd_t;

    typedef struct {
        int          len;
        logic [31:0] src;
        logic [31:0] dst;
        int          stall;
        int          err_at;
        int          restart_at;
        int          pattern;
        logic [31:0] w0;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    logic [31:0] mem [bit [31:0]];
    cmd_t        obs_q[$];
    cmd_t        exp_q[$];
    logic [31:0] src_words[$];

    int n_cmp = 0;
    int n_bad = 0;

    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int viol = 0;
    int stall_max = 0;
    int err_at = 0;
    int nreads = 0;
    bit busy_seen = 0;

    bit          rsp_pend = 0;
    int          rsp_wait = 0;
    logic [31:0] rsp_data = '0;
    logic        rsp_e = 1'b0;
    int          cmd_wait = 0;
    bit          prev_valid = 0;
    bit          prev_hs = 0;
    bit          hs = 0;
    cmd_t        held = '0;
    cmd_t        cur_raw = '0;
    cmd_t        logged = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ICB slave: decides this cycle's ready/valid on the falling edge, so any handshake
    // it grants here completes at the next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            icb_cmd_ready = 1'b0;
            icb_rsp_valid = 1'b0;
            rsp_pend      = 0;
            prev_valid    = 0;
            prev_hs       = 0;
        end else begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (busy) viol++;
            end
            if (busy) busy_seen = 1;

            if (rsp_pend) begin
                if (rsp_wait > 0) begin
                    rsp_wait--;
                    icb_rsp_valid = 1'b0;
                    icb_rsp_err   = 1'($urandom_range(0, 1));
                    icb_rsp_rdata = $urandom;
                end else begin
                    icb_rsp_valid = 1'b1;
                    icb_rsp_rdata = rsp_data;
                    icb_rsp_err   = rsp_e;
                    if (icb_rsp_ready) rsp_pend = 0;
                end
            end else begin
                icb_rsp_valid = 1'b0;
                icb_rsp_err   = 1'($urandom_range(0, 1));
                icb_rsp_rdata = $urandom;
            end

            cur_raw = '{icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask};
            hs = 0;
            if (icb_cmd_valid) begin
                if (prev_valid && !prev_hs && cur_raw != held) viol++;
                if (!prev_valid || prev_hs) cmd_wait = $urandom_range(0, stall_max);
                if (cmd_wait > 0) begin
                    cmd_wait--;
                    icb_cmd_ready = 1'b0;
                end else begin
                    icb_cmd_ready = 1'b1;
                    hs = 1;
                end
                held = cur_raw;
                if (hs) begin
                    logged = cur_raw;
                    if (icb_cmd_read) begin
                        logged.data = 32'h0;
                        nreads++;
                        rsp_data = mem.exists(icb_cmd_addr) ? mem[icb_cmd_addr] : $urandom;
                        rsp_e    = (nreads == err_at);
                    end else begin
                        mem[icb_cmd_addr] = icb_cmd_wdata;
                        rsp_data = $urandom;
                        rsp_e    = 1'b0;
                    end
                    obs_q.push_back(logged);
                    rsp_pend = 1;
                    rsp_wait = $urandom_range(0, stall_max);
                end
            end else begin
                if (prev_valid && !prev_hs) viol++;
                icb_cmd_ready = 1'($urandom_range(0, 1));
            end
            prev_valid = icb_cmd_valid;
            prev_hs    = hs;
        end
    end

    // Copy model: chunks of DEPTH words, each read fully then written in order; an error
    // response on read number err_at ends the job with that chunk unwritten.
    task automatic build_expected(input vec_t v, output int written);
        int   nrd;
        bit   stop;
        int   n;
        cmd_t c;
        nrd = 0;
        stop = 0;
        written = 0;
        exp_q.delete();
        for (int base = 0; base < v.len && !stop; base += DEPTH) begin
            n = (v.len - base < DEPTH) ? (v.len - base) : DEPTH;
            for (int i = 0; i < n; i++) begin
                c = '{1'b1, v.src + 32'(4 * (base + i)), 32'h0, 4'h0};
                exp_q.push_back(c);
                nrd++;
                if (nrd == v.err_at) stop = 1;
                if (stop) break;
            end
            if (!stop) begin
                for (int i = 0; i < n; i++) begin
                    c = '{1'b0, v.dst + 32'(4 * (base + i)), src_words[base + i], 4'hF};
                    exp_q.push_back(c);
                end
                written += n;
            end
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          written;
        int          k;
        int          t0;
        int          nc;
        string       tag;
        logic [31:0] w;
        tag = $sformatf("v%0d", idx);
        src_words.delete();
        for (int i = 0; i < v.len; i++) begin
            w = (v.pattern == 1) ? 32'(i) : $urandom;
            if (i == 0 && v.w0 != 32'h0) w = v.w0;
            src_words.push_back(w);
            mem[v.src + 32'(4 * i)] = w;
            mem[v.dst + 32'(4 * i)] = 32'h5A5A_0000 | 32'(i);
        end
        build_expected(v, written);

        obs_q.delete();
        viol      = 0;
        done_cnt  = 0;
        busy_seen = 0;
        nreads    = 0;
        stall_max = v.stall;
        err_at    = v.err_at;

        @(negedge clk); #1;
        start    = 1'b1;
        src_addr = v.src;
        dst_addr = v.dst;
        len      = LW'(v.len);
        t0       = cyc;
        @(negedge clk); #1;
        start    = 1'b0;
        src_addr = $urandom;
        dst_addr = $urandom;
        len      = LW'($urandom);
        check($sformatf("%s.busy_rise", tag), busy, (v.len != 0));

        k = 1;
        while (done_cnt == 0 && k < 3000) begin
            if (k == v.restart_at) begin
                start    = 1'b1;
                src_addr = v.src + 32'h100;
                dst_addr = v.dst + 32'h100;
                len      = LW'(7);
            end else begin
                start = 1'b0;
            end
            @(negedge clk); #1;
            k++;
        end
        start = 1'b0;
        check($sformatf("%s.done_seen", tag), (done_cnt != 0), 1'b1);
        // Inclusive count from the start cycle through the done cycle.
        if (v.exp_lat >= 0) check($sformatf("%s.latency", tag), done_cyc - t0 + 1, v.exp_lat);

        repeat (3) begin
            @(negedge clk); #1;
        end
        check($sformatf("%s.done_once", tag), done_cnt, 1);
        check($sformatf("%s.err", tag), err, v.exp_err);
        check($sformatf("%s.busy_seen", tag), busy_seen, (v.len != 0));
        check($sformatf("%s.protocol", tag), viol, 0);
        check($sformatf("%s.cmd_count", tag), obs_q.size(), exp_q.size());
        nc = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < nc; i++) begin
            check($sformatf("%s.cmd%0d", tag, i), obs_q[i], exp_q[i]);
        end
        for (int i = 0; i < v.len; i++) begin
            check($sformatf("%s.dst%0d", tag, i), mem[v.dst + 32'(4 * i)],
                  (i < written) ? src_words[i] : (32'h5A5A_0000 | 32'(i)));
        end
    endtask

    vec_t vecs[10];
    vec_t post_rst;

    initial begin
        int k;
        vecs[0] = '{1,  32'h1000_0000, 32'h1004_0000, 0, 0, 0, 0, 32'hDEAD_BEEF, 1'b0, 6};
        vecs[1] = '{6,  32'h2000_0000, 32'h2010_0000, 0, 0, 0, 1, 32'h0, 1'b0, 26};
        vecs[2] = '{9,  32'h2100_0000, 32'h2110_0000, 5, 0, 0, 0, 32'h0, 1'b0, -1};
        vecs[3] = '{0,  32'h2200_0000, 32'h2210_0000, 0, 0, 0, 0, 32'h0, 1'b0, 2};
        vecs[4] = '{4,  32'h2300_0000, 32'h2310_0000, 0, 0, 3, 0, 32'h0, 1'b0, 18};
        vecs[5] = '{8,  32'h2400_0000, 32'h2410_0000, 0, 3, 0, 0, 32'h0, 1'b1, -1};
        vecs[6] = '{2,  32'h2500_0000, 32'h2510_0000, 0, 0, 0, 0, 32'h0, 1'b0, 10};
        vecs[7] = '{3,  32'hFFFF_FFF8, 32'h2610_0000, 0, 0, 0, 0, 32'h0, 1'b0, 14};
        vecs[8] = '{16, 32'h2700_0000, 32'h2710_0000, 3, 0, 0, 0, 32'h0, 1'b0, -1};
        vecs[9] = '{5,  32'h2800_0000, 32'h2810_0000, 2, 5, 0, 0, 32'h0, 1'b1, -1};
        post_rst = '{2, 32'h3100_0000, 32'h3110_0000, 1, 0, 0, 0, 32'h0, 1'b0, -1};

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset.outputs",
              {icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
               icb_rsp_ready, busy, done, err}, '0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset while a write command is waiting on the bus.
        stall_max = 3;
        err_at    = 0;
        @(negedge clk); #1;
        start    = 1'b1;
        src_addr = 32'h3000_0000;
        dst_addr = 32'h3010_0000;
        len      = LW'(6);
        @(negedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!(icb_cmd_valid && !icb_cmd_read) && k < 500) begin
            @(negedge clk); #1;
            k++;
        end
        check("rst.reach_wr_cmd", (icb_cmd_valid && !icb_cmd_read), 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst.cmd_valid", icb_cmd_valid, 1'b0);
        check("rst.busy", busy, 1'b0);
        check("rst.rsp_ready", icb_rsp_ready, 1'b0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst_n = 1'b1;
        run_vec(10, post_rst);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/icb_dma_master.md
# icb_dma_master

ICB initiator that copies a block of 32-bit words from a source address to a destination address, one outstanding transaction at a time. Data is staged in an internal buffer of FIFO_DEPTH words. It sits on the system bus in front of the accelerator's ICB slave and loads operand SRAMs or drains results without CPU load/store loops. Control is a start pulse plus address/length inputs driven by a CPU-visible register block.

## Interface
- FIFO_DEPTH, 4, staging buffer depth in words; power of two, 2..16.
- LEN_W, 13, width of the length field in words.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request; sampled only in IDLE.
- src_addr  in  32  byte address of the first source word; word aligned.
- dst_addr  in  32  byte address of the first destination word; word aligned.
- len  in  LEN_W  number of words to copy; 0 is legal.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at completion or abort.
- err  out  1  sticky error flag; cleared by the next accepted start.
- icb_cmd_valid  out  1  command valid.
- icb_cmd_ready  in  1  command ready.
- icb_cmd_read  out  1  1 = read, 0 = write.
- icb_cmd_addr  out  32  command byte address.
- icb_cmd_wdata  out  32  write data.
- icb_cmd_wmask  out  4  4'hF on writes, 4'h0 on reads.
- icb_rsp_valid  in  1  response valid.
- icb_rsp_ready  out  1  response ready.
- icb_rsp_rdata  in  32  read data.
- icb_rsp_err  in  1  response error.

## Operation
- States: IDLE, RD_CMD, RD_RSP, WR_CMD, WR_RSP, FIN.
- Start handling:
  - IDLE with start=1: latch src_addr, dst_addr and len, and clear err.
  - If len=0, go to FIN. Otherwise set chunk = min(remaining, FIFO_DEPTH) and go to RD_CMD.
  - start is ignored in every other state.
- RD_CMD: drive a read at the source pointer. On cmd handshake, go to RD_RSP.
- RD_RSP: on rsp handshake, store rdata at buffer index rd_idx and add 4 to the source pointer.
  - If chunk words have been read, go to WR_CMD with wr_idx=0.
  - Otherwise go back to RD_CMD.
- WR_CMD: drive a write at the destination pointer with wdata = buffer[wr_idx]. On cmd handshake, go to WR_RSP.
- WR_RSP: on rsp handshake, add 4 to the destination pointer and decrement remaining.
  - Chunk finished and remaining=0: go to FIN.
  - Chunk finished and remaining>0: reload chunk and go to RD_CMD.
  - Chunk not finished: go to WR_CMD.
- FIN: assert done for one cycle, then go to IDLE.
- Error: icb_rsp_err=1 on any accepted response sets err and goes to FIN. Remaining words are not transferred. Read data from an errored response is not written.
- Address arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- Word order is preserved exactly: destination word i = source word i.

## Timing
- Reset values: icb_cmd_valid=0, icb_cmd_read=0, icb_cmd_addr=0, icb_cmd_wdata=0, icb_cmd_wmask=0, icb_rsp_ready=0, busy=0, done=0, err=0, state=IDLE. Buffer contents are don't-care.
- All outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.
- Command handshake rules:
  - icb_cmd_valid is high exactly in RD_CMD/WR_CMD.
  - Once valid is high, cmd_read, cmd_addr, cmd_wdata and cmd_wmask stay stable until the cycle with valid&ready.
  - Valid never drops without a handshake.
- Response handshake rules:
  - icb_rsp_ready is high exactly in RD_RSP/WR_RSP.
  - A response presented during a CMD state waits; the slave holds it.
- A command issues the cycle after the previous response is accepted.
- Minimum latency with a zero-wait slave (cmd_ready=1, response one cycle after cmd handshake) is 4N+2 cycles from start to done for a single-chunk transfer of N words.
- busy and done:
  - busy rises the cycle after start and falls in the same cycle done rises.
  - For len=0, done is high 1 cycle after start and busy never rises.
- Reset asserted mid-transfer returns to the reset state immediately. The bus transaction in flight is abandoned.

## Test plan
- len=1, src=0x1000_0000 holding 0xDEAD_BEEF, dst=0x1004_0000, zero-wait slave -> one read then one write of 0xDEAD_BEEF with wmask F; done in cycle 6 after start; err=0.
- len=6, FIFO_DEPTH=4, src holds 0..5 -> bus order: 4 reads, 4 writes, 2 reads, 2 writes; addresses step by 4; dst holds 0..5.
- Random cmd_ready/rsp_valid stalls of 0-5 cycles on len=9 -> command fields stable while stalled, no dropped or duplicated words, done exactly once.
- len=0 -> done 1 cycle after start, no icb_cmd_valid, busy stays 0; a second start while busy during a len=4 transfer is ignored.
- rsp_err=1 on the 3rd read of len=8 -> no further commands, err=1, done pulses; the next start clears err.
- rst_n pulsed low while in WR_CMD -> cmd_valid=0 and busy=0 immediately; a following len=2 transfer completes correctly.
